// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: two one-entry writeback slots (A = ALU,
// B = load) commit oldest-first, and both read ports bypass pending slot data.
module regfile_write_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              AValid,
    output logic              AReady,
    input  logic [AWIDTH-1:0] AAddr,
    input  logic [WIDTH-1:0]  AData,
    input  logic              BValid,
    output logic              BReady,
    input  logic [AWIDTH-1:0] BAddr,
    input  logic [WIDTH-1:0]  BData,
    output logic [AWIDTH-1:0] WriteRegister,
    output logic [WIDTH-1:0]  WriteData,
    output logic              RegWrite,
    input  logic [AWIDTH-1:0] ReadRegister1,
    input  logic [AWIDTH-1:0] ReadRegister2,
    input  logic [WIDTH-1:0]  RfReadData1,
    input  logic [WIDTH-1:0]  RfReadData2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    typedef enum logic [2:0] {
        StIdle,
        StOnlyA,
        StOnlyB,
        StBothAOld,
        StBothBOld
    } arb_state_e;

    logic              full_a_q, full_a_d;
    logic              full_b_q, full_b_d;
    logic [AWIDTH-1:0] addr_a_q, addr_a_d;
    logic [AWIDTH-1:0] addr_b_q, addr_b_d;
    logic [WIDTH-1:0]  data_a_q, data_a_d;
    logic [WIDTH-1:0]  data_b_q, data_b_d;
    logic              older_b_q, older_b_d;

    arb_state_e        state;
    logic              grant_a, grant_b;
    logic              load_a, load_b;

    // Arbiter state is a pure decode of the slot flags and the age bit
    always_comb begin
        state = StIdle;
        if (full_a_q && full_b_q) begin
            state = older_b_q ? StBothBOld : StBothAOld;
        end else if (full_a_q) begin
            state = StOnlyA;
        end else if (full_b_q) begin
            state = StOnlyB;
        end
    end

    // Grant from registered state only; a slot is ready when empty or committing now
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (state)
            StOnlyA, StBothAOld: grant_a = 1'b1;
            StOnlyB, StBothBOld: grant_b = 1'b1;
            default: ;
        endcase
        AReady = Reset_n & (~full_a_q | grant_a);
        BReady = Reset_n & (~full_b_q | grant_b);
        // Writes to r0 complete the handshake but never occupy a slot
        load_a = AValid & AReady & (AAddr != '0);
        load_b = BValid & BReady & (BAddr != '0);
    end

    // Slot and age next-state
    always_comb begin
        full_a_d  = full_a_q;
        full_b_d  = full_b_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        older_b_d = older_b_q;
        if (grant_a) full_a_d = 1'b0;
        if (grant_b) full_b_d = 1'b0;
        if (load_a) begin
            full_a_d = 1'b1;
            addr_a_d = AAddr;
            data_a_d = AData;
        end
        if (load_b) begin
            full_b_d = 1'b1;
            addr_b_d = BAddr;
            data_b_d = BData;
        end
        // Same-edge loads treat A as older so B's write lands last
        if (load_a && load_b) begin
            older_b_d = 1'b0;
        end else if (load_a && full_b_q && !grant_b) begin
            older_b_d = 1'b1;
        end else if (load_b && full_a_q && !grant_a) begin
            older_b_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            full_a_q  <= 1'b0;
            full_b_q  <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            older_b_q <= 1'b0;
        end else begin
            full_a_q  <= full_a_d;
            full_b_q  <= full_b_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            older_b_q <= older_b_d;
        end
    end

    // Write port driven by the granted slot; quiet during reset
    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        if (Reset_n && grant_a) begin
            RegWrite      = 1'b1;
            WriteRegister = addr_a_q;
            WriteData     = data_a_q;
        end else if (Reset_n && grant_b) begin
            RegWrite      = 1'b1;
            WriteRegister = addr_b_q;
            WriteData     = data_b_q;
        end
    end

    function automatic logic [WIDTH-1:0] bypass(
        input logic [AWIDTH-1:0] rr,
        input logic [WIDTH-1:0]  rf,
        input logic              fa,
        input logic [AWIDTH-1:0] aa,
        input logic [WIDTH-1:0]  da,
        input logic              fb,
        input logic [AWIDTH-1:0] ab,
        input logic [WIDTH-1:0]  db,
        input logic              ob
    );
        logic hit_a, hit_b;
        hit_a = fa && (aa == rr);
        hit_b = fb && (ab == rr);
        if (rr == '0)             return '0;
        // On a double hit the younger slot holds the newest value
        if (hit_a && hit_b)       return ob ? da : db;
        if (hit_a)                return da;
        if (hit_b)                return db;
        return rf;
    endfunction

    // Read-port bypass of pending writes
    always_comb begin
        ReadData1 = bypass(ReadRegister1, RfReadData1, full_a_q, addr_a_q, data_a_q,
                           full_b_q, addr_b_q, data_b_q, older_b_q);
        ReadData2 = bypass(ReadRegister2, RfReadData2, full_a_q, addr_a_q, data_a_q,
                           full_b_q, addr_b_q, data_b_q, older_b_q);
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters, A (ALU result) and B (memory load). Each requester has a one-entry holding slot and a valid/ready handshake. Writes commit to the register file oldest-first. Until a buffered write commits, both read ports bypass its data so consumers never see a stale value. The block sits between the writeback sources and `regfile`, driving its write port and post-processing its two combinational read ports.

## Interface
- `WIDTH`, 32: data width.
- `AWIDTH`, 5: register address width (32 registers; register 0 reads as zero).

- `Clk`  in  1  clock, positive-edge.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `AValid`  in  1  requester A has a write.
- `AReady`  out  1  A may hand over; transfer on `AValid & AReady` at the rising edge.
- `AAddr`  in  AWIDTH  A destination register.
- `AData`  in  WIDTH  A write data.
- `BValid`, `BReady`, `BAddr`, `BData`: same as the A ports, for requester B.
- `WriteRegister`  out  AWIDTH  to `regfile`.
- `WriteData`  out  WIDTH  to `regfile`.
- `RegWrite`  out  1  to `regfile`.
- `ReadRegister1`, `ReadRegister2`  in  AWIDTH  read addresses, also wired directly to `regfile`.
- `RfReadData1`, `RfReadData2`  in  WIDTH  raw `regfile` read data (combinational read).
- `ReadData1`, `ReadData2`  out  WIDTH  bypassed read data to consumers.

## Operation
- **State registers:**
  - `FullA`/`FullB` slot flags.
  - Slot address and data for each requester.
  - `OlderB`, meaningful only when both slots are full.
- **Arbiter states** (derived from the registers):
  - IDLE: no slot full.
  - ONLY_A, ONLY_B: one slot full.
  - BOTH_AOLD, BOTH_BOLD: both full, distinguished by `OlderB`.
- **Grant:**
  - ONLY_A → A; ONLY_B → B.
  - BOTH_AOLD → A; BOTH_BOLD → B.
  - IDLE → none.
  - Grant depends only on registered state, never on `AValid`/`BValid`.
- **Write port:**
  - Granted slot drives `WriteRegister`/`WriteData` with `RegWrite=1`.
  - With no grant, all three are 0.
  - The granted slot empties at the next rising edge (the commit).
- **Ready:**
  - `AReady = Reset_n & (~FullA | GrantA)`; `BReady` is symmetric.
  - A slot can therefore be refilled on the same edge it commits.
- **Accept:**
  - A transfer loads address and data into the slot and sets its Full flag.
  - A transfer with address 0 completes the handshake, but the slot is not filled and no `RegWrite` is ever issued for it.
- **Age:**
  - A loaded while B stays full → `OlderB=1`.
  - B loaded while A stays full → `OlderB=0`.
  - Both loaded on the same edge → `OlderB=0` (A is treated as older, so B's write lands last).
  - Same-register writes therefore commit in acceptance order.
- **Bypass, per read port N:**
  - `ReadRegisterN==0` → 0.
  - Else a full slot with a matching address supplies its data.
  - If both slots match, the younger slot wins.
  - Otherwise `RfReadDataN`.
- **Starvation bound:** a full slot commits within 2 cycles of being loaded.

## Timing
- **Reset** (`Reset_n` low at a rising edge):
  - Edge effect: `FullA=FullB=0`, `OlderB=0`, slot contents 0.
  - Combinational while low: `RegWrite`, `AReady`, `BReady` = 0, so no commit and no accept occur.
- **Reset mid-operation:** buffered writes are discarded and never reach `regfile`.
- **Outputs after reset:**
  - `WriteRegister=0`, `WriteData=0`, `RegWrite=0`.
  - `ReadDataN` pass through `RfReadDataN`, or 0 for register 0.
- **Latency:** accept at edge k → `RegWrite` high during cycle k+1 at earliest → commit at edge k+1.
  - If the other slot is older, commit moves to edge k+2.
- **Bypass window:** from the cycle after accept until the commit edge. Afterwards `RfReadDataN` already holds the value.
- **Throughput:** one commit per cycle total. Each requester can sustain one write every cycle while the other is idle.
- **Simultaneous commit and accept on the same slot:** the old entry commits and the new entry loads, with no bubble.

## Test plan
1. Reset, then A writes r2=42 → `RegWrite=1`, `WriteRegister=2`, `WriteData=42` the next cycle. Afterwards read ports 1 and 2 at r2 both return 42.
2. A (r3=7) and B (r3=9) on the same edge → commit r3=7, then r3=9. Bypass reads 9 while both are pending; final regfile r3=9.
3. A writes r0=15 → handshake completes, `RegWrite` stays 0, and `ReadData1`/`ReadData2` at r0 both return 0.
4. A asserts `AValid` every cycle with r5..r8 while B is idle → `AReady` stays 1 and there are 4 consecutive `RegWrite` cycles.
5. Both slots full (B older, r4=1; A r6=2) → B commits first. `BReady=1` in that cycle, and a new B offer is taken while A commits next.
6. Load A with r9=99, assert `Reset_n=0` for one cycle → no `RegWrite` ever occurs for r9, `AReady=0` during reset, and `AReady=1` afterwards.
